// File: rtl/key_scan_scheduler_if.sv
// Event queue handshake between the key scanner (master) and its consumer (slave).
interface key_scan_scheduler_if #(
   parameter int unsigned NKEYS = 8
);
   localparam int unsigned KW = $clog2(NKEYS);

   logic          evt_valid;
   logic [KW-1:0] evt_key;
   logic          evt_press;
   logic          evt_ready;

   modport master (
      output evt_valid,
      output evt_key,
      output evt_press,
      input  evt_ready
   );

   modport slave (
      input  evt_valid,
      input  evt_key,
      input  evt_press,
      output evt_ready
   );
endinterface

// File: rtl/key_scan_scheduler.sv
// Debounces NKEYS raw sensor inputs with one shared, time-multiplexed counter
// engine and queues press/release events in a small FIFO.
module key_scan_scheduler #(
   parameter int unsigned NKEYS        = 8,
   parameter int unsigned TICK_DIV     = 2700,
   parameter int unsigned STABLE_TICKS = 100,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NKEYS-1:0]     keys_in,
   output logic [NKEYS-1:0]     steady,
   key_scan_scheduler_if.master evt,
   output logic                 busy
);

   localparam int unsigned KW = $clog2(NKEYS);
   localparam int unsigned CW = $clog2(STABLE_TICKS) + 1;
   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned FW = AW + 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_STALL
   } state_t;

   // Synchronizer and prescaler
   logic [NKEYS-1:0] sync_meta_q;
   logic [NKEYS-1:0] sync_q;
   logic [PW-1:0]    presc_q;
   logic [PW-1:0]    presc_d;
   logic             tick;

   // Scheduler state
   state_t           state_q, state_d;
   logic [KW-1:0]    idx_q, idx_d;
   logic             pending_q, pending_d;

   // Per-key debounce state
   logic [NKEYS-1:0] steady_q;
   logic [CW-1:0]    cnt_q [NKEYS];

   // Shared engine view of the key being scanned
   logic             cur_sync;
   logic             cur_steady;
   logic [CW-1:0]    cur_cnt;
   logic             key_differs;
   logic             cnt_due;
   logic             cnt_we;
   logic [CW-1:0]    cnt_wdata;
   logic             steady_we;
   logic             advance;

   // Event FIFO
   logic [KW:0]      fifo_mem_q [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [FW-1:0]    fill_q;
   logic             fifo_full;
   logic             push_en;
   logic             pop_en;
   logic [KW:0]      push_data;
   logic [KW:0]      head_data;

   // Two-flop synchronizer for the asynchronous sensor levels
   always_ff @(posedge clock) begin
      if (reset) begin
         sync_meta_q <= '0;
         sync_q      <= '0;
      end else begin
         sync_meta_q <= keys_in;
         sync_q      <= sync_meta_q;
      end
   end

   assign tick    = (presc_q == PW'(TICK_DIV - 1));
   assign presc_d = tick ? '0 : presc_q + PW'(1);

   // Scan-tick prescaler
   always_ff @(posedge clock) begin
      if (reset) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_d;
      end
   end

   assign cur_sync    = sync_q[idx_q];
   assign cur_steady  = steady_q[idx_q];
   assign cur_cnt     = cnt_q[idx_q];
   assign key_differs = (cur_sync != cur_steady);
   assign cnt_due     = (cur_cnt == CW'(STABLE_TICKS - 1));
   assign fifo_full   = (fill_q == FW'(FIFO_DEPTH));
   assign push_data   = {idx_q, cur_sync};

   // Scheduler next state and per-key update decisions
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      pending_d = pending_q;
      cnt_we    = 1'b0;
      cnt_wdata = '0;
      steady_we = 1'b0;
      push_en   = 1'b0;
      advance   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (tick || pending_q) begin
               state_d   = ST_SCAN;
               idx_d     = '0;
               pending_d = 1'b0;
            end
         end
         ST_SCAN: begin
            if (tick) pending_d = 1'b1;
            if (!key_differs) begin
               cnt_we  = 1'b1;
               advance = 1'b1;
            end else if (!cnt_due) begin
               cnt_we    = 1'b1;
               cnt_wdata = cur_cnt + CW'(1);
               advance   = 1'b1;
            end else if (!fifo_full) begin
               cnt_we    = 1'b1;
               steady_we = 1'b1;
               push_en   = 1'b1;
               advance   = 1'b1;
            end else begin
               state_d = ST_STALL;
            end
         end
         ST_STALL: begin
            if (tick) pending_d = 1'b1;
            // The held key is re-evaluated against its current level, so a
            // bounce back during the stall drops the event instead of pushing it.
            if (!fifo_full) begin
               cnt_we    = 1'b1;
               steady_we = key_differs;
               push_en   = key_differs;
               advance   = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (advance) begin
         if (idx_q == KW'(NKEYS - 1)) begin
            state_d = ST_IDLE;
         end else begin
            idx_d   = idx_q + KW'(1);
            state_d = ST_SCAN;
         end
      end
   end

   // Scheduler state register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         pending_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         pending_q <= pending_d;
      end
   end

   // Per-key debounce state, one key written per clock
   always_ff @(posedge clock) begin
      if (reset) begin
         steady_q <= '0;
         for (int unsigned i = 0; i < NKEYS; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         if (cnt_we)    cnt_q[idx_q]    <= cnt_wdata;
         if (steady_we) steady_q[idx_q] <= cur_sync;
      end
   end

   assign pop_en = (fill_q != '0) && evt.evt_ready;

   // FIFO pointers and fill level; fullness uses the registered fill only
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
      end else begin
         if (push_en) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_en)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push_en, pop_en})
            2'b10:   fill_q <= fill_q + FW'(1);
            2'b01:   fill_q <= fill_q - FW'(1);
            default: fill_q <= fill_q;
         endcase
      end
   end

   // FIFO storage; contents are qualified by the fill level
   always_ff @(posedge clock) begin
      if (push_en) fifo_mem_q[wr_ptr_q] <= push_data;
   end

   assign head_data     = fifo_mem_q[rd_ptr_q];
   assign evt.evt_valid = (fill_q != '0);
   assign evt.evt_key   = head_data[KW:1];
   assign evt.evt_press = head_data[0];
   assign steady        = steady_q;
   assign busy          = (state_q != ST_IDLE);

endmodule
